bin_to_sseg_digits: RTL and testbench
=====================================

// Module: bin_to_sseg_digits
// PURPOSE
//  Converts a binary value (servo angle or count) into four 7-segment digit codes.
//  Conversion is sequential shift-add-3 (double dabble), one bit per clock.
//  Sits directly upstream of the 4-digit display multiplexer and drives its in3..in0.
//  Outputs hold the last completed result, so the display never shows partial conversions.
// PARAMETERS
//  W         14  binary input width; W=14 covers 0..16383
//  BLANK_LZ  1   1 = blank leading zeros (digit 0 is never blanked); 0 = show them
// PORTS
//  clk       in   1   system clock; the block uses this one clock only
//  reset     in   1   synchronous, active-high reset
//  start     in   1   1-cycle request; accepted only in IDLE
//  value     in   W   binary value; sampled on the clock edge that accepts start
//  busy      out  1   high while a conversion is in progress
//  done      out  1   1-cycle pulse on the cycle dig3..dig0 update
//  dig3      out  7   thousands digit code {g,f,e,d,c,b,a}, active-low
//  dig2      out  7   hundreds digit code, same format
//  dig1      out  7   tens digit code, same format
//  dig0      out  7   units digit code, same format
// BEHAVIOUR
//  Reset values (sync): state=IDLE, busy=0, done=0, dig3..dig0=7'h7F (all segments off).
//  FSM states:
//   IDLE
//    - start=1: latch value into shift reg, clear 16-bit BCD reg, bit_cnt=W-1, go CONV.
//    - Otherwise stay in IDLE.
//   CONV
//    - Each cycle: add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
//    - bit_cnt==0: go LOAD; else decrement bit_cnt.
//   LOAD
//    - Encode nibbles to dig3..dig0, done=1 for this cycle, go IDLE.
//  busy:
//   - busy=1 in CONV and LOAD; busy=0 in IDLE.
//   - busy is combinational from state.
//  Latency: start accepted at edge 0 -> done=1 and new digits visible W+1 cycles later.
//   - With W=14: start accepted at edge 0, done=1 in cycle 15.
//   - start to the next start: min W+2 cycles (back-to-back allowed on the cycle after done).
//  start while busy=1 is ignored; it is neither queued nor does it alter the conversion.
//  Overflow
//   - Latched value >9999: LOAD writes dash 7'h3F to all four digits.
//   - The BCD result is discarded.
//  Digit encoding, active-low gfedcba:
//   - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
//  BLANK_LZ=1
//   - Digits from dig3 downward are blank (7'h7F) while each is zero.
//   - Blanking stops at the first nonzero digit.
//   - dig0 always shows its digit.
//  reset in CONV/LOAD
//   - Aborts the conversion, returns to IDLE, digits go blank, no done pulse.
//  value may change freely after acceptance; only the latched copy is used.
// STRUCTURE
//  Shared header sseg_defs.vh holds:
//   - `define constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F
//   - FSM state encodings IDLE=2'd0, CONV=2'd1, LOAD=2'd2
//  Sub-module bcd_to_sseg (4-bit BCD in -> 7-bit active-low code out, combinational):
//   - instantiated 4x
//  Top holds the FSM, bit counter, shift registers, blanking and output registers.
// TESTING
//  reset, start with value=1234
//   -> after 15 cycles done=1 for one cycle
//   -> dig3..dig0 = 79,24,30,19
//  value=0, BLANK_LZ=1 -> 7F,7F,7F,40
//  value=0, BLANK_LZ=0 -> 40,40,40,40
//  value=9999 -> 10,10,10,10
//  value=10000 -> 3F,3F,3F,3F
//  value=16383 -> 3F,3F,3F,3F
//  value=7, then start=1 pulsed again at cycle 5 with value=8
//   -> second start ignored
//   -> single done pulse, digits show 7 (7F,7F,7F,78)
//  value=42 done; start value=305; reset asserted at cycle 8 of that conversion
//   -> digits 7F x4, busy=0, no done pulse
//   -> next start with value=305 -> 7F,30,40,12
//  Back-to-back 56 then 78 (second start on the cycle after done)
//   -> two done pulses 16 cycles apart
//   -> digits hold 7F,7F,12,02 until the second done pulse
//   -> then 7F,7F,78,00

Source files
------------

// File: rtl/bin_to_sseg_digits_pkg.sv
// Shared types and constants for the binary to 7-segment digit converter.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package bin_to_sseg_digits_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Largest value that fits in four decimal digits.
  localparam int unsigned MAX_DISPLAY = 9999;

  // Double-dabble correction step: bump every BCD nibble of 5 or more by 3
  // so the following left shift carries correctly into the next decade.
  function automatic logic [15:0] bcd_add3(input logic [15:0] bcd);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/bin_to_sseg_digits_bcd_to_sseg.sv
// Combinational BCD digit to active-low 7-segment code {g,f,e,d,c,b,a}.
// Codes 10..15 never reach a display and are shown blank.
module bcd_to_sseg
  import bin_to_sseg_digits_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_sseg_digits.sv
// Sequential double-dabble converter feeding four 7-segment digit registers.
// Digit outputs change only when a conversion completes, never mid-conversion.
module bin_to_sseg_digits
  import bin_to_sseg_digits_pkg::*;
#(
  parameter int W        = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         done,
  output logic [6:0]   dig3,
  output logic [6:0]   dig2,
  output logic [6:0]   dig1,
  output logic [6:0]   dig0
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  // Compare width wide enough to hold both the input and MAX_DISPLAY.
  localparam int VW = (W > 14) ? W : 14;

  state_t          state;
  logic [W-1:0]    bin_sr;
  logic [15:0]     bcd_sr;
  logic [CW-1:0]   bit_cnt;
  logic            ovf;

  logic [6:0]      seg_raw  [4];
  logic [6:0]      seg_next [4];
  logic [3:0]      lead_zero;

  for (genvar i = 0; i < 4; i++) begin : g_enc
    bcd_to_sseg u_enc (
      .bcd (bcd_sr[4*i +: 4]),
      .seg (seg_raw[i])
    );
  end

  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    lead_zero[3] = BLANK_LZ && (bcd_sr[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (bcd_sr[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (bcd_sr[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ovf)               seg_next[i] = SEG_DASH;
      else if (lead_zero[i]) seg_next[i] = SEG_BLANK;
      else                   seg_next[i] = seg_raw[i];
    end
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      dig3    <= SEG_BLANK;
      dig2    <= SEG_BLANK;
      dig1    <= SEG_BLANK;
      dig0    <= SEG_BLANK;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= value;
            bcd_sr  <= '0;
            bit_cnt <= CW'(W - 1);
            ovf     <= (VW'(value) > VW'(MAX_DISPLAY));
            state   <= CONV;
          end
        end
        CONV: begin
          {bcd_sr, bin_sr} <= {bcd_add3(bcd_sr), bin_sr} << 1;
          if (bit_cnt == '0) state <= LOAD;
          else               bit_cnt <= bit_cnt - CW'(1);
        end
        LOAD: begin
          dig3  <= seg_next[3];
          dig2  <= seg_next[2];
          dig1  <= seg_next[1];
          dig0  <= seg_next[0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_sseg_digits.sv
// Directed and randomized checks of bin_to_sseg_digits against a decimal reference model.
// Two instances share stimulus: one blanks leading zeros, one shows them.
module tb_bin_to_sseg_digits;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] value;

  logic         busy_b, done_b, busy_r, done_r;
  logic [6:0]   d3_b, d2_b, d1_b, d0_b, d3_r, d2_r, d1_r, d0_r;
  logic [27:0]  dig_b, dig_r;

  int checks = 0;
  int errors = 0;

  assign dig_b = {d3_b, d2_b, d1_b, d0_b};
  assign dig_r = {d3_r, d2_r, d1_r, d0_r};

  always #5 clk = ~clk;

  bin_to_sseg_digits #(.W(W), .BLANK_LZ(1'b1)) dut_blz (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (value),
    .busy  (busy_b),
    .done  (done_b),
    .dig3  (d3_b),
    .dig2  (d2_b),
    .dig1  (d1_b),
    .dig0  (d0_b)
  );

  bin_to_sseg_digits #(.W(W), .BLANK_LZ(1'b0)) dut_raw (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (value),
    .busy  (busy_r),
    .done  (done_r),
    .dig3  (d3_r),
    .dig2  (d2_r),
    .dig1  (d1_r),
    .dig0  (d0_r)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected {dig3,dig2,dig1,dig0} from decimal arithmetic.
  function automatic logic [27:0] ref_digits(input int v, input bit blz);
    int          d [4];
    logic [27:0] r;
    bit          leading;
    if (v > 9999) return {4{7'h3F}};
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = v / 1000;
    leading = blz;
    for (int k = 3; k >= 0; k--) begin
      if (leading && k > 0 && d[k] == 0) begin
        r[7*k +: 7] = 7'h7F;
      end else begin
        leading = 1'b0;
        r[7*k +: 7] = seg_of(d[k]);
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int v);
    value = W'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    value = W'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_b && n < 40);
  endtask

  task automatic check_result(input string tag, input int v);
    check({tag, " digits blz"}, 32'(dig_b), 32'(ref_digits(v, 1'b1)));
    check({tag, " digits raw"}, 32'(dig_r), 32'(ref_digits(v, 1'b0)));
  endtask

  task automatic convert(input string tag, input int v);
    int n;
    accept(v);
    check({tag, " busy"}, 32'(busy_b), 32'd1);
    wait_done(n);
    check({tag, " latency"}, n, 15);
    check({tag, " done raw"}, 32'(done_r), 32'd1);
    check_result(tag, v);
    tick();
    check({tag, " done width"}, 32'({done_b, done_r}), 32'd0);
  endtask

  initial begin
    int n, dones, done_at, v;
    bit hold_ok;

    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) tick();
    check("reset busy", 32'({busy_b, busy_r}), 32'd0);
    check("reset done", 32'({done_b, done_r}), 32'd0);
    check("reset digits blz", 32'(dig_b), 32'(28'hFFFFFFF));
    check("reset digits raw", 32'(dig_r), 32'(28'hFFFFFFF));
    reset = 1'b0;
    tick();

    convert("v1234", 1234);
    convert("v0", 0);
    convert("v9999", 9999);
    convert("v10000", 10000);
    convert("v16383", 16383);

    // A second start while busy must be ignored.
    accept(7);
    dones   = 0;
    done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        start = 1'b1;
        value = W'(8);
      end
      tick();
      start = 1'b0;
      if (done_b) begin
        dones++;
        done_at = c;
      end
    end
    check("ignored start done count", dones, 1);
    check("ignored start done cycle", done_at, 15);
    check_result("ignored start", 7);

    // Reset mid-conversion aborts without a done pulse.
    convert("v42", 42);
    accept(305);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 32'({busy_b, busy_r}), 32'd0);
    check("abort done", 32'({done_b, done_r}), 32'd0);
    check("abort digits blz", 32'(dig_b), 32'(28'hFFFFFFF));
    check("abort digits raw", 32'(dig_r), 32'(28'hFFFFFFF));
    dones = 0;
    repeat (20) begin
      tick();
      if (done_b || done_r) dones++;
    end
    check("abort no done", dones, 0);
    check("abort digits held", 32'(dig_b), 32'(28'hFFFFFFF));
    convert("v305", 305);

    // Back-to-back: second start on the cycle after done.
    accept(56);
    wait_done(n);
    check("b2b first latency", n, 15);
    check_result("b2b first", 56);
    start   = 1'b1;
    value   = W'(78);
    n       = 0;
    hold_ok = 1'b1;
    do begin
      tick();
      start = 1'b0;
      n++;
      if (!done_b && (dig_b !== ref_digits(56, 1'b1) || dig_r !== ref_digits(56, 1'b0)))
        hold_ok = 1'b0;
    end while (!done_b && n < 40);
    check("b2b done spacing", n, 16);
    check("b2b digits held", 32'(hold_ok), 32'd1);
    check_result("b2b second", 78);
    tick();

    repeat (16) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 16383));
      else                           v = int'($urandom_range(0, 9999));
      convert($sformatf("rand %0d", v), v);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
